aes_ctr_ctrl: RTL and testbench

CTR-mode sequencer for the AES-256 block core. Accepts a 256-bit key and 128-bit initial counter block, then streams 128-bit data blocks through a valid/ready interface. Each block is processed by launching one core encryption of the current counter block and XORing the returned keystream with the data. The same logic serves encryption and decryption. The block sits between the system data stream and a single AES-256 core instance, which it owns exclusively.

---
 rtl/aes_ctr_ctrl.sv | 137 +++++++++++++
 tb/tb_aes_ctr_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ctr_ctrl.sv
// aes_ctr_ctrl
// CTR-mode sequencer wrapped around a single AES-256 block core. It latches
// a key and an initial counter block, then for every data block launches one
// core encryption of the counter block and XORs the keystream with the data.
// Encryption and decryption are the same operation in CTR mode.

module aes_ctr_ctrl #(
  parameter int CTR_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] key_i,
  input  logic [127:0] iv_i,
  input  logic         cfg_valid_i,
  output logic         cfg_ready_o,
  input  logic         flush_i,
  input  logic [127:0] din_i,
  input  logic         din_valid_i,
  output logic         din_ready_o,
  output logic [127:0] dout_o,
  output logic         dout_valid_o,
  input  logic         dout_ready_i,
  output logic         core_start_o,
  output logic [255:0] core_key_o,
  output logic [127:0] core_block_o,
  input  logic         core_done_i,
  input  logic [127:0] core_result_i,
  output logic         busy_o,
  output logic [31:0]  blk_count_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READY,
    ST_LAUNCH,
    ST_WAIT,
    ST_OUT
  } state_t;

  // Bits of the counter block that advance per block; the rest is a fixed nonce.
  localparam logic [127:0] CTR_MASK = (CTR_WIDTH >= 128) ? {128{1'b1}}
                                    : ((128'd1 << CTR_WIDTH) - 128'd1);

  state_t        state;
  state_t        state_next;
  logic [255:0]  key_q;
  logic [127:0]  ctr_q;
  logic [127:0]  data_q;
  logic [127:0]  dout_q;
  logic          dout_valid_q;
  logic [31:0]   blk_count_q;
  logic [127:0]  ctr_inc;

  // Carry out of the counter field is dropped so the upper nonce never changes.
  assign ctr_inc = (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; flush overrides every other transition.
  always_comb begin
    state_next = state;
    if (flush_i) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (cfg_valid_i)  state_next = ST_READY;
        ST_READY:  if (din_valid_i)  state_next = ST_LAUNCH;
        ST_LAUNCH:                   state_next = ST_WAIT;
        ST_WAIT:   if (core_done_i)  state_next = ST_OUT;
        ST_OUT:    if (dout_ready_i) state_next = ST_READY;
        default:                     state_next = ST_IDLE;
      endcase
    end
  end

  // Datapath registers: config capture, data capture, keystream XOR and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q        <= '0;
      ctr_q        <= '0;
      data_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      blk_count_q  <= '0;
    end else if (flush_i) begin
      dout_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_valid_i) begin
            key_q       <= key_i;
            ctr_q       <= iv_i;
            blk_count_q <= '0;
          end
        end
        ST_READY: begin
          if (din_valid_i) begin
            data_q <= din_i;
          end
        end
        ST_WAIT: begin
          if (core_done_i) begin
            dout_q       <= data_q ^ core_result_i;
            dout_valid_q <= 1'b1;
            ctr_q        <= ctr_inc;
            blk_count_q  <= blk_count_q + 32'd1;
          end
        end
        ST_OUT: begin
          if (dout_ready_i) begin
            dout_valid_q <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign cfg_ready_o  = (state == ST_IDLE);
  assign din_ready_o  = (state == ST_READY);
  assign core_start_o = (state == ST_LAUNCH);
  assign busy_o       = (state == ST_LAUNCH) || (state == ST_WAIT) || (state == ST_OUT);
  assign core_key_o   = key_q;
  assign core_block_o = ctr_q;
  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;
  assign blk_count_o  = blk_count_q;

endmodule

// File: tb/tb_aes_ctr_ctrl.sv
// tb_aes_ctr_ctrl
// Drives aes_ctr_ctrl against a stub core whose result is the launched counter
// block XOR both key halves, returned a fixed number of cycles after start.

module tb_aes_ctr_ctrl;

  localparam int CORE_LAT = 3;

  logic         clk;
  logic         rst;
  logic [255:0] key_i;
  logic [127:0] iv_i;
  logic         cfg_valid_i;
  logic         cfg_ready_o;
  logic         flush_i;
  logic [127:0] din_i;
  logic         din_valid_i;
  logic         din_ready_o;
  logic [127:0] dout_o;
  logic         dout_valid_o;
  logic         dout_ready_i;
  logic         core_start_o;
  logic [255:0] core_key_o;
  logic [127:0] core_block_o;
  logic         core_done_i;
  logic [127:0] core_result_i;
  logic         busy_o;
  logic [31:0]  blk_count_o;

  logic         stray_done;
  int           stub_cnt;
  logic [127:0] stub_res;
  logic [127:0] last_start_block;

  int checks;
  int errors;

  typedef struct {
    logic [255:0] key;
    logic [127:0] iv;
    logic [127:0] din;
    logic [127:0] exp_dout;
    logic [127:0] exp_ctr;
  } vec_t;

  vec_t vecs[4];

  aes_ctr_ctrl #(.CTR_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .key_i         (key_i),
    .iv_i          (iv_i),
    .cfg_valid_i   (cfg_valid_i),
    .cfg_ready_o   (cfg_ready_o),
    .flush_i       (flush_i),
    .din_i         (din_i),
    .din_valid_i   (din_valid_i),
    .din_ready_o   (din_ready_o),
    .dout_o        (dout_o),
    .dout_valid_o  (dout_valid_o),
    .dout_ready_i  (dout_ready_i),
    .core_start_o  (core_start_o),
    .core_key_o    (core_key_o),
    .core_block_o  (core_block_o),
    .core_done_i   (core_done_i),
    .core_result_i (core_result_i),
    .busy_o        (busy_o),
    .blk_count_o   (blk_count_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stub core: a start pulse (re)launches it; done fires CORE_LAT cycles later.
  always @(posedge clk) begin
    if (rst) begin
      stub_cnt <= 0;
      stub_res <= '0;
    end else if (core_start_o) begin
      stub_cnt         <= CORE_LAT;
      stub_res         <= core_block_o ^ core_key_o[255:128] ^ core_key_o[127:0];
      last_start_block <= core_block_o;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
    end
  end

  assign core_done_i   = (stub_cnt == 1) || stray_done;
  assign core_result_i = (stub_cnt == 1) ? stub_res : 128'hDEADBEEF_CAFEF00D_0BADC0DE_FEEDFACE;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic fl, input logic cv, input logic [255:0] k,
                               input logic [127:0] iv);
    flush_i     = fl;
    cfg_valid_i = cv;
    key_i       = k;
    iv_i        = iv;
    tick();
    flush_i     = 1'b0;
    cfg_valid_i = 1'b0;
  endtask

  task automatic runBlock(input logic [127:0] din, output int lat, output int starts);
    din_i       = din;
    din_valid_i = 1'b1;
    tick();
    din_valid_i = 1'b0;
    lat    = 0;
    starts = 0;
    while (!dout_valid_o && lat < 50) begin
      if (core_start_o) starts++;
      tick();
      lat++;
    end
  endtask

  task automatic acceptOut();
    dout_ready_i = 1'b1;
    tick();
    dout_ready_i = 1'b0;
  endtask

  initial begin
    int  lat;
    int  starts;
    logic [127:0] held;
    logic stable;
    logic din_rdy_seen;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    key_i = '0;
    iv_i = '0;
    cfg_valid_i = 1'b0;
    flush_i = 1'b0;
    din_i = '0;
    din_valid_i = 1'b0;
    dout_ready_i = 1'b0;
    stray_done = 1'b0;

    vecs[0] = '{256'h0, 128'h0, 128'hC3, 128'hC3, 128'h1};
    vecs[1] = '{{128'h0, 128'h0F0F0F0F_0F0F0F0F_0F0F0F0F_0F0F0F0F}, 128'h1,
                128'hF0F0F0F0_F0F0F0F0_F0F0F0F0_F0F0F0F0,
                128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 128'h2};
    vecs[2] = '{{128'hFF, 128'h0}, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5, 128'h0,
                128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A55A,
                128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A6};
    vecs[3] = '{256'h0, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_FFFFFFFF, 128'h12345678,
                128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_EDCBA987,
                128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_00000000};

    tick();
    tick();
    checkOutput("rst_cfg_ready", {255'd0, cfg_ready_o}, 256'd1);
    checkOutput("rst_din_ready", {255'd0, din_ready_o}, 256'd0);
    checkOutput("rst_dout", {128'd0, dout_o}, 256'd0);
    checkOutput("rst_busy", {255'd0, busy_o}, 256'd0);
    checkOutput("rst_core_key", core_key_o, 256'd0);
    rst = 1'b0;
    tick();
    checkOutput("idle_cfg_ready", {255'd0, cfg_ready_o}, 256'd1);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, '0, '0);
      applyStimulus(1'b0, 1'b1, vecs[i].key, vecs[i].iv);
      checkOutput($sformatf("v%0d_din_ready", i), {255'd0, din_ready_o}, 256'd1);
      checkOutput($sformatf("v%0d_core_key", i), core_key_o, vecs[i].key);
      checkOutput($sformatf("v%0d_blk_clr", i), {224'd0, blk_count_o}, 256'd0);
      runBlock(vecs[i].din, lat, starts);
      checkOutput($sformatf("v%0d_latency", i), lat, CORE_LAT + 1);
      checkOutput($sformatf("v%0d_starts", i), starts, 1);
      checkOutput($sformatf("v%0d_dout", i), {128'd0, dout_o}, {128'd0, vecs[i].exp_dout});
      checkOutput($sformatf("v%0d_ctr", i), {128'd0, core_block_o}, {128'd0, vecs[i].exp_ctr});
      checkOutput($sformatf("v%0d_blk", i), {224'd0, blk_count_o}, 256'd1);
      checkOutput($sformatf("v%0d_busy", i), {255'd0, busy_o}, 256'd1);
      acceptOut();
      checkOutput($sformatf("v%0d_valid_clr", i), {255'd0, dout_valid_o}, 256'd0);
      checkOutput($sformatf("v%0d_din_ready_back", i), {255'd0, din_ready_o}, 256'd1);
    end

    // Counter wrap across two blocks
    applyStimulus(1'b1, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b1, 256'h0, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_FFFFFFFF);
    runBlock(128'h0, lat, starts);
    checkOutput("wrap_dout1", {128'd0, dout_o}, {128'd0, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_FFFFFFFF});
    acceptOut();
    checkOutput("wrap_ctr", {128'd0, core_block_o}, {128'd0, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_00000000});
    runBlock(128'h0, lat, starts);
    checkOutput("wrap_launch_block", {128'd0, last_start_block},
                {128'd0, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_00000000});
    checkOutput("wrap_dout2", {128'd0, dout_o}, {128'd0, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_00000000});
    checkOutput("wrap_blk", {224'd0, blk_count_o}, 256'd2);
    acceptOut();

    // Backpressure: hold output for ten cycles
    applyStimulus(1'b1, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b1, 256'h0, 128'h10);
    runBlock(128'h55555555_55555555_55555555_55555555, lat, starts);
    held = dout_o;
    stable = 1'b1;
    din_rdy_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (dout_o !== held || dout_valid_o !== 1'b1) stable = 1'b0;
      if (din_ready_o) din_rdy_seen = 1'b1;
    end
    checkOutput("bp_dout", {128'd0, held}, {128'd0, 128'h55555555_55555555_55555555_55555545});
    checkOutput("bp_stable", {255'd0, stable}, 256'd1);
    checkOutput("bp_din_ready", {255'd0, din_rdy_seen}, 256'd0);
    acceptOut();
    checkOutput("bp_valid_clr", {255'd0, dout_valid_o}, 256'd0);
    checkOutput("bp_din_ready_after", {255'd0, din_ready_o}, 256'd1);

    // Flush during WAIT, late and stray done while IDLE
    applyStimulus(1'b1, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b1, {128'h0, 128'h3}, 128'h100);
    din_i = 128'h7;
    din_valid_i = 1'b1;
    tick();
    din_valid_i = 1'b0;
    tick();
    applyStimulus(1'b1, 1'b0, '0, '0);
    checkOutput("fl_cfg_ready", {255'd0, cfg_ready_o}, 256'd1);
    checkOutput("fl_busy", {255'd0, busy_o}, 256'd0);
    tick();
    tick();
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    checkOutput("fl_idle", {255'd0, cfg_ready_o}, 256'd1);
    checkOutput("fl_valid", {255'd0, dout_valid_o}, 256'd0);
    checkOutput("fl_dout_kept", {128'd0, dout_o}, {128'd0, 128'h55555555_55555555_55555555_55555545});
    checkOutput("fl_ctr_kept", {128'd0, core_block_o}, {128'd0, 128'h100});
    applyStimulus(1'b0, 1'b1, {128'h0, 128'h30}, 128'h200);
    runBlock(128'h9, lat, starts);
    checkOutput("fl_new_dout", {128'd0, dout_o}, {128'd0, 128'h239});
    acceptOut();

    // Stray done while READY
    applyStimulus(1'b1, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b1, 256'h0, 128'h40);
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    tick();
    checkOutput("sr_valid", {255'd0, dout_valid_o}, 256'd0);
    checkOutput("sr_din_ready", {255'd0, din_ready_o}, 256'd1);
    checkOutput("sr_ctr", {128'd0, core_block_o}, {128'd0, 128'h40});
    checkOutput("sr_blk", {224'd0, blk_count_o}, 256'd0);

    // Reset while WAIT
    din_i = 128'h1;
    din_valid_i = 1'b1;
    tick();
    din_valid_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checkOutput("rw_cfg_ready", {255'd0, cfg_ready_o}, 256'd1);
    checkOutput("rw_din_ready", {255'd0, din_ready_o}, 256'd0);
    checkOutput("rw_valid", {255'd0, dout_valid_o}, 256'd0);
    checkOutput("rw_start", {255'd0, core_start_o}, 256'd0);
    checkOutput("rw_busy", {255'd0, busy_o}, 256'd0);
    checkOutput("rw_dout", {128'd0, dout_o}, 256'd0);
    checkOutput("rw_blk", {224'd0, blk_count_o}, 256'd0);
    checkOutput("rw_block", {128'd0, core_block_o}, 256'd0);
    checkOutput("rw_key", core_key_o, 256'd0);
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
